// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI3 field widths, burst and response encodings, and the state and
// priority enums used by axi_sram_slave and axi_burst_addr_gen.
// No ports (package).
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int STRB_W = DATA_W / 8;

    // Burst encodings. 2'b11 is reserved on the bus and handled as INCR.
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Response encodings.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD      = 2'd1,
        ST_WR_DATA = 2'd2,
        ST_WR_RESP = 2'd3
    } state_e;

    // Which channel wins when AR and AW are both valid in IDLE.
    typedef enum logic {
        PRIO_RD = 1'b0,
        PRIO_WR = 1'b1
    } prio_e;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// -----------------------------------------------------------------------------
// axi_burst_addr_gen
// Combinational next-beat address for AXI3 FIXED / INCR / WRAP bursts on a
// 32-bit data bus. Transfer sizes wider than the bus are clamped to 4 bytes.
//
// Ports:
//   addr_i      in  32  current beat address
//   size_i      in  3   AxSIZE (bytes per beat = 1 << size, clamped to 4)
//   len_i       in  4   AxLEN (beats - 1)
//   burst_i     in  2   AxBURST
//   next_addr_o out 32  address of the following beat
// -----------------------------------------------------------------------------
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o
);

    logic [1:0]        shift;
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic [ADDR_W-1:0] wrap_addr;

    assign shift     = (size_i > 3'd2) ? 2'd2 : size_i[1:0];
    assign step      = ADDR_W'(1) << shift;
    assign incr_addr = addr_i + step;

    // Wrap window is (len+1)*step bytes, aligned to its own size. Legal WRAP
    // lengths (2/4/8/16 beats) make the window a power of two, so the wrap is
    // a mask: upper bits come from the current address, lower bits from the
    // incremented address.
    assign wrap_mask = (ADDR_W'({1'b0, len_i} + 5'd1) << shift) - ADDR_W'(1);
    assign wrap_addr = (addr_i & ~wrap_mask) | (incr_addr & wrap_mask);

    always_comb begin
        next_addr_o = incr_addr;
        case (burst_i)
            BURST_FIXED: next_addr_o = addr_i;
            BURST_WRAP:  next_addr_o = wrap_addr;
            default:     next_addr_o = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// -----------------------------------------------------------------------------
// axi_sram_slave
// AXI3 slave backed by an on-chip word-addressed SRAM array. Serves one read
// or write burst at a time (FIXED/INCR/WRAP, up to 16 beats, byte strobes),
// with alternating AR/AW priority when both are requested together.
//
// Optional feature: define AXI_SRAM_ERR_RESP_EN to enable the address window
// check. Out-of-window read beats return zero data with SLVERR; out-of-window
// write beats are dropped and the burst completes with SLVERR. Without the
// macro, addresses alias modulo the array depth and responses are OKAY.
//
// Parameters:
//   ADDR_BASE   byte address of word 0
//   DEPTH_LOG2  log2 of the array depth in 32-bit words
//
// Ports:
//   clock, reset                 clock; synchronous active-high reset
//   axi_ar_chl_*                 read address channel (lock/cache/prot unused)
//   axi_r_chl_*                  read data channel
//   axi_aw_chl_*                 write address channel (lock/cache/prot unused)
//   axi_w_chl_*                  write data channel (wid/wlast unused; the
//                                burst length comes from awlen)
//   axi_b_chl_*                  write response channel
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; payload is held stable while valid is high and ready is low.
// -----------------------------------------------------------------------------
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_BASE  = 32'h8000_0000,
    parameter int                DEPTH_LOG2 = 10
)
(
    input  logic              clock,
    input  logic              reset,

    input  logic              axi_ar_chl_valid,
    output logic              axi_ar_chl_ready,
    input  logic [ID_W-1:0]   axi_ar_chl_bits_arid,
    input  logic [ADDR_W-1:0] axi_ar_chl_bits_araddr,
    input  logic [2:0]        axi_ar_chl_bits_arsize,
    input  logic [LEN_W-1:0]  axi_ar_chl_bits_arlen,
    input  logic [1:0]        axi_ar_chl_bits_arbusrt,
    input  logic [1:0]        axi_ar_chl_bits_arlock,
    input  logic [1:0]        axi_ar_chl_bits_arcache,
    input  logic [1:0]        axi_ar_chl_bits_arprot,

    output logic              axi_r_chl_valid,
    input  logic              axi_r_chl_ready,
    output logic [DATA_W-1:0] axi_r_chl_bits_rdata,
    output logic [ID_W-1:0]   axi_r_chl_bits_rid,
    output logic [1:0]        axi_r_chl_bits_rresp,
    output logic              axi_r_chl_bits_rlast,

    input  logic              axi_aw_chl_valid,
    output logic              axi_aw_chl_ready,
    input  logic [ID_W-1:0]   axi_aw_chl_bits_awid,
    input  logic [ADDR_W-1:0] axi_aw_chl_bits_awaddr,
    input  logic [2:0]        axi_aw_chl_bits_awsize,
    input  logic [LEN_W-1:0]  axi_aw_chl_bits_awlen,
    input  logic [1:0]        axi_aw_chl_bits_awbusrt,
    input  logic [1:0]        axi_aw_chl_bits_awlock,
    input  logic [1:0]        axi_aw_chl_bits_awcache,
    input  logic [1:0]        axi_aw_chl_bits_awprot,

    input  logic              axi_w_chl_valid,
    output logic              axi_w_chl_ready,
    input  logic [DATA_W-1:0] axi_w_chl_bits_wdata,
    input  logic [ID_W-1:0]   axi_w_chl_bits_wid,
    input  logic [STRB_W-1:0] axi_w_chl_bits_wstrb,
    input  logic              axi_w_chl_bits_wlast,

    output logic              axi_b_chl_valid,
    input  logic              axi_b_chl_ready,
    output logic [ID_W-1:0]   axi_b_chl_bits_bid,
    output logic [1:0]        axi_b_chl_bits_bresp
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_e            state_q, state_d;
    prio_e             prio_q,  prio_d;
    logic [ID_W-1:0]   id_q,    id_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  beat_q,  beat_d;
    logic [2:0]        size_q,  size_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q,   err_d;   // some beat of this write was dropped

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0]     next_addr;
    logic [DEPTH_LOG2-1:0] cur_idx;
    logic                  beat_ok;
    logic                  last_beat;
    logic                  ar_hs, aw_hs, r_hs, w_hs, b_hs;
    logic                  unused_inputs;

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - ADDR_BASE) >> 2);
    endfunction

    // ---------------------------------------------------------------------
    // Shared burst address generator (used by both RD and WR_DATA)
    // ---------------------------------------------------------------------
    axi_burst_addr_gen u_addr_gen (
        .addr_i      (addr_q),
        .size_i      (size_q),
        .len_i       (len_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    assign cur_idx   = word_idx(addr_q);
    assign last_beat = (beat_q == len_q);

`ifdef AXI_SRAM_ERR_RESP_EN
    // In window iff the offset from the base fits in the array; addresses
    // below the base wrap to huge offsets and fail the same test.
    assign beat_ok = (((addr_q - ADDR_BASE) >> (DEPTH_LOG2 + 2)) == '0);
`else
    assign beat_ok = 1'b1;
`endif

    // ---------------------------------------------------------------------
    // Channel outputs. Readies/valids are held low while reset is asserted.
    // ---------------------------------------------------------------------
    assign axi_ar_chl_ready = !reset && (state_q == ST_IDLE)
                              && (!axi_aw_chl_valid || (prio_q == PRIO_RD));
    assign axi_aw_chl_ready = !reset && (state_q == ST_IDLE)
                              && (!axi_ar_chl_valid || (prio_q == PRIO_WR));
    assign axi_r_chl_valid  = !reset && (state_q == ST_RD);
    assign axi_w_chl_ready  = !reset && (state_q == ST_WR_DATA);
    assign axi_b_chl_valid  = !reset && (state_q == ST_WR_RESP);

    assign axi_r_chl_bits_rdata = (axi_r_chl_valid && beat_ok) ? mem[cur_idx] : '0;
    assign axi_r_chl_bits_rid   = axi_r_chl_valid ? id_q : '0;
    assign axi_r_chl_bits_rresp = (axi_r_chl_valid && !beat_ok) ? RESP_SLVERR : RESP_OKAY;
    assign axi_r_chl_bits_rlast = axi_r_chl_valid && last_beat;

    assign axi_b_chl_bits_bid   = axi_b_chl_valid ? id_q : '0;
    assign axi_b_chl_bits_bresp = (axi_b_chl_valid && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign ar_hs = axi_ar_chl_valid && axi_ar_chl_ready;
    assign aw_hs = axi_aw_chl_valid && axi_aw_chl_ready;
    assign r_hs  = axi_r_chl_valid  && axi_r_chl_ready;
    assign w_hs  = axi_w_chl_valid  && axi_w_chl_ready;
    assign b_hs  = axi_b_chl_valid  && axi_b_chl_ready;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        addr_d  = addr_q;
        len_d   = len_q;
        beat_d  = beat_q;
        size_d  = size_q;
        burst_d = burst_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                // The arbitration in the ready terms guarantees at most one
                // of these handshakes per cycle.
                if (ar_hs) begin
                    id_d    = axi_ar_chl_bits_arid;
                    addr_d  = axi_ar_chl_bits_araddr;
                    len_d   = axi_ar_chl_bits_arlen;
                    size_d  = axi_ar_chl_bits_arsize;
                    burst_d = axi_ar_chl_bits_arbusrt;
                    beat_d  = '0;
                    prio_d  = PRIO_WR;
                    state_d = ST_RD;
                end else if (aw_hs) begin
                    id_d    = axi_aw_chl_bits_awid;
                    addr_d  = axi_aw_chl_bits_awaddr;
                    len_d   = axi_aw_chl_bits_awlen;
                    size_d  = axi_aw_chl_bits_awsize;
                    burst_d = axi_aw_chl_bits_awbusrt;
                    beat_d  = '0;
                    err_d   = 1'b0;
                    prio_d  = PRIO_RD;
                    state_d = ST_WR_DATA;
                end
            end

            ST_RD: begin
                if (r_hs) begin
                    addr_d = next_addr;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_WR_DATA: begin
                if (w_hs) begin
                    addr_d = next_addr;
                    beat_d = beat_q + 1'b1;
                    err_d  = err_q || !beat_ok;
                    if (last_beat) begin
                        state_d = ST_WR_RESP;
                    end
                end
            end

            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            prio_q  <= PRIO_RD;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------------
    // Array write port. Contents survive reset; w_hs is already low while
    // reset is asserted because wready is gated by it.
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_hs && beat_ok) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (axi_w_chl_bits_wstrb[i]) begin
                    mem[cur_idx][8*i +: 8] <= axi_w_chl_bits_wdata[8*i +: 8];
                end
            end
        end
    end

    assign unused_inputs = ^{axi_ar_chl_bits_arlock, axi_ar_chl_bits_arcache,
                             axi_ar_chl_bits_arprot, axi_aw_chl_bits_awlock,
                             axi_aw_chl_bits_awcache, axi_aw_chl_bits_awprot,
                             axi_w_chl_bits_wid, axi_w_chl_bits_wlast};

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clock;
    logic        reset;

    logic        axi_ar_chl_valid;
    logic        axi_ar_chl_ready;
    logic [3:0]  axi_ar_chl_bits_arid;
    logic [31:0] axi_ar_chl_bits_araddr;
    logic [2:0]  axi_ar_chl_bits_arsize;
    logic [3:0]  axi_ar_chl_bits_arlen;
    logic [1:0]  axi_ar_chl_bits_arbusrt;
    logic [1:0]  axi_ar_chl_bits_arlock;
    logic [1:0]  axi_ar_chl_bits_arcache;
    logic [1:0]  axi_ar_chl_bits_arprot;

    logic        axi_r_chl_valid;
    logic        axi_r_chl_ready;
    logic [31:0] axi_r_chl_bits_rdata;
    logic [3:0]  axi_r_chl_bits_rid;
    logic [1:0]  axi_r_chl_bits_rresp;
    logic        axi_r_chl_bits_rlast;

    logic        axi_aw_chl_valid;
    logic        axi_aw_chl_ready;
    logic [3:0]  axi_aw_chl_bits_awid;
    logic [31:0] axi_aw_chl_bits_awaddr;
    logic [2:0]  axi_aw_chl_bits_awsize;
    logic [3:0]  axi_aw_chl_bits_awlen;
    logic [1:0]  axi_aw_chl_bits_awbusrt;
    logic [1:0]  axi_aw_chl_bits_awlock;
    logic [1:0]  axi_aw_chl_bits_awcache;
    logic [1:0]  axi_aw_chl_bits_awprot;

    logic        axi_w_chl_valid;
    logic        axi_w_chl_ready;
    logic [31:0] axi_w_chl_bits_wdata;
    logic [3:0]  axi_w_chl_bits_wid;
    logic [3:0]  axi_w_chl_bits_wstrb;
    logic        axi_w_chl_bits_wlast;

    logic        axi_b_chl_valid;
    logic        axi_b_chl_ready;
    logic [3:0]  axi_b_chl_bits_bid;
    logic [1:0]  axi_b_chl_bits_bresp;

    axi_sram_slave dut (
        .clock                   (clock),
        .reset                   (reset),
        .axi_ar_chl_valid        (axi_ar_chl_valid),
        .axi_ar_chl_ready        (axi_ar_chl_ready),
        .axi_ar_chl_bits_arid    (axi_ar_chl_bits_arid),
        .axi_ar_chl_bits_araddr  (axi_ar_chl_bits_araddr),
        .axi_ar_chl_bits_arsize  (axi_ar_chl_bits_arsize),
        .axi_ar_chl_bits_arlen   (axi_ar_chl_bits_arlen),
        .axi_ar_chl_bits_arbusrt (axi_ar_chl_bits_arbusrt),
        .axi_ar_chl_bits_arlock  (axi_ar_chl_bits_arlock),
        .axi_ar_chl_bits_arcache (axi_ar_chl_bits_arcache),
        .axi_ar_chl_bits_arprot  (axi_ar_chl_bits_arprot),
        .axi_r_chl_valid         (axi_r_chl_valid),
        .axi_r_chl_ready         (axi_r_chl_ready),
        .axi_r_chl_bits_rdata    (axi_r_chl_bits_rdata),
        .axi_r_chl_bits_rid      (axi_r_chl_bits_rid),
        .axi_r_chl_bits_rresp    (axi_r_chl_bits_rresp),
        .axi_r_chl_bits_rlast    (axi_r_chl_bits_rlast),
        .axi_aw_chl_valid        (axi_aw_chl_valid),
        .axi_aw_chl_ready        (axi_aw_chl_ready),
        .axi_aw_chl_bits_awid    (axi_aw_chl_bits_awid),
        .axi_aw_chl_bits_awaddr  (axi_aw_chl_bits_awaddr),
        .axi_aw_chl_bits_awsize  (axi_aw_chl_bits_awsize),
        .axi_aw_chl_bits_awlen   (axi_aw_chl_bits_awlen),
        .axi_aw_chl_bits_awbusrt (axi_aw_chl_bits_awbusrt),
        .axi_aw_chl_bits_awlock  (axi_aw_chl_bits_awlock),
        .axi_aw_chl_bits_awcache (axi_aw_chl_bits_awcache),
        .axi_aw_chl_bits_awprot  (axi_aw_chl_bits_awprot),
        .axi_w_chl_valid         (axi_w_chl_valid),
        .axi_w_chl_ready         (axi_w_chl_ready),
        .axi_w_chl_bits_wdata    (axi_w_chl_bits_wdata),
        .axi_w_chl_bits_wid      (axi_w_chl_bits_wid),
        .axi_w_chl_bits_wstrb    (axi_w_chl_bits_wstrb),
        .axi_w_chl_bits_wlast    (axi_w_chl_bits_wlast),
        .axi_b_chl_valid         (axi_b_chl_valid),
        .axi_b_chl_ready         (axi_b_chl_ready),
        .axi_b_chl_bits_bid      (axi_b_chl_bits_bid),
        .axi_b_chl_bits_bresp    (axi_b_chl_bits_bresp)
    );

    // ------------------------------------------------------------------
    // Clock / watchdog
    // ------------------------------------------------------------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Scoreboard state and reference model
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [1:0]  rresp_q[$];
    logic [1:0]  bresp_q[$];
    logic [31:0] model_mem [int];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'(off[11:2]);
    endfunction

    function automatic bit in_win(input logic [31:0] a);
`ifdef AXI_SRAM_ERR_RESP_EN
        return (a >= BASE) && ({1'b0, a} < ({1'b0, BASE} + 33'd4096));
`else
        return (a == a);
`endif
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        int i;
        i = widx(a);
        return model_mem.exists(i) ? model_mem[i] : 32'h0;
    endfunction

    function automatic void model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        v = model_rd(a);
        for (int b = 0; b < 4; b++)
            if (s[b]) v[8*b +: 8] = d[8*b +: 8];
        model_mem[widx(a)] = v;
    endfunction

    // Next beat address from the burst definition (window base by division).
    function automatic logic [31:0] nxt(input logic [31:0] a, input logic [2:0] size,
                                        input logic [3:0] len, input logic [1:0] burst);
        longint unsigned av, step, win, base;
        av   = a;
        step = (size >= 3'd2) ? 4 : (64'd1 << size);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) begin
            win  = (64'(len) + 1) * step;
            base = (av / win) * win;
            return 32'(base + ((av - base + step) % win));
        end
        return 32'(av + step);
    endfunction

    function automatic logic sig(input int s);
        case (s)
            0:       return axi_ar_chl_ready;
            1:       return axi_aw_chl_ready;
            2:       return axi_w_chl_ready;
            default: return axi_r_chl_valid;
        endcase
    endfunction

    // Called just after a negedge; waits (bounded) for the selected signal.
    task automatic wait_hi(input int s, input string name);
        int n;
        n = 0;
        #1;
        while (!sig(s) && n < 50) begin
            @(negedge clock);
            #1;
            n++;
        end
        check(name, 32'(sig(s)), 32'd1);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size,
                            input logic [31:0] data0, input logic [3:0] strb,
                            output logic [1:0] bresp_seen);
        logic [31:0] a;
        bit err;
        a = addr;
        err = 0;
        for (int i = 0; i <= int'(len); i++) begin
            if (in_win(a)) model_wr(a, data0 + 32'(i), strb);
            else err = 1;
            a = nxt(a, size, len, burst);
        end
        bresp_q.push_back(err ? 2'b10 : 2'b00);

        @(negedge clock);
        axi_aw_chl_valid        = 1'b1;
        axi_aw_chl_bits_awid    = id;
        axi_aw_chl_bits_awaddr  = addr;
        axi_aw_chl_bits_awlen   = len;
        axi_aw_chl_bits_awsize  = size;
        axi_aw_chl_bits_awbusrt = burst;
        wait_hi(1, "aw_ready");
        @(posedge clock);
        @(negedge clock);
        axi_aw_chl_valid = 1'b0;
        #1 check("w_lat", 32'(axi_w_chl_ready), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            axi_w_chl_valid      = 1'b1;
            axi_w_chl_bits_wdata = data0 + 32'(i);
            axi_w_chl_bits_wstrb = strb;
            axi_w_chl_bits_wlast = (i == int'(len));
            wait_hi(2, "w_ready");
            @(posedge clock);
            @(negedge clock);
        end
        axi_w_chl_valid = 1'b0;
        #1;
        check("b_rise", 32'(axi_b_chl_valid), 32'd1);
        check("b_id", 32'(axi_b_chl_bits_bid), 32'(id));
        bresp_seen = axi_b_chl_bits_bresp;
        if (bresp_q.size() == 0) check("b_sb_empty", 32'd1, 32'd0);
        else check("b_resp", 32'(axi_b_chl_bits_bresp), 32'(bresp_q.pop_front()));
        axi_b_chl_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_b_chl_ready = 1'b0;
        #1 check("b_end", 32'(axi_b_chl_valid), 32'd0);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [2:0] size, input bit toggle,
                           output logic [31:0] first_data, output logic [1:0] first_resp);
        logic [31:0] a;
        int beats, cyc;
        exp_q.delete();
        rresp_q.delete();
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            if (in_win(a)) begin
                exp_q.push_back(model_rd(a));
                rresp_q.push_back(2'b00);
            end else begin
                exp_q.push_back(32'h0);
                rresp_q.push_back(2'b10);
            end
            a = nxt(a, size, len, burst);
        end
        first_data = '0;
        first_resp = '0;

        @(negedge clock);
        axi_ar_chl_valid        = 1'b1;
        axi_ar_chl_bits_arid    = id;
        axi_ar_chl_bits_araddr  = addr;
        axi_ar_chl_bits_arlen   = len;
        axi_ar_chl_bits_arsize  = size;
        axi_ar_chl_bits_arbusrt = burst;
        wait_hi(0, "ar_ready");
        @(posedge clock);
        @(negedge clock);
        axi_ar_chl_valid = 1'b0;
        #1 check("rd_lat", 32'(axi_r_chl_valid), 32'd1);
        beats = 0;
        cyc = 0;
        while (beats <= int'(len) && cyc < 60) begin
            axi_r_chl_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            #1;
            check("rd_valid", 32'(axi_r_chl_valid), 32'd1);
            if (exp_q.size() == 0) begin
                check("rd_sb_empty", 32'd1, 32'd0);
                break;
            end
            // During stalls the payload must keep matching the head beat.
            check("rd_data", axi_r_chl_bits_rdata, exp_q[0]);
            check("rd_resp", 32'(axi_r_chl_bits_rresp), 32'(rresp_q[0]));
            check("rd_id", 32'(axi_r_chl_bits_rid), 32'(id));
            check("rd_last", 32'(axi_r_chl_bits_rlast), 32'(beats == int'(len)));
            if (axi_r_chl_valid && axi_r_chl_ready) begin
                if (beats == 0) begin
                    first_data = axi_r_chl_bits_rdata;
                    first_resp = axi_r_chl_bits_rresp;
                end
                void'(exp_q.pop_front());
                void'(rresp_q.pop_front());
                beats++;
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
        check("rd_beats", 32'(beats), 32'(len) + 32'd1);
        axi_r_chl_ready = 1'b0;
        #1 check("rd_end", 32'(axi_r_chl_valid), 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [1:0]  burst;
        logic [2:0]  size;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          toggle;
        logic [31:0] exp_first;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] fd;
        logic [1:0]  fr;
        logic [31:0] e_word0, e_ovf_rd;
        logic [1:0]  e_err;
        bit          seen;

        axi_ar_chl_valid = 0; axi_ar_chl_bits_arid = 0; axi_ar_chl_bits_araddr = 0;
        axi_ar_chl_bits_arsize = 0; axi_ar_chl_bits_arlen = 0; axi_ar_chl_bits_arbusrt = 0;
        axi_ar_chl_bits_arlock = 0; axi_ar_chl_bits_arcache = 0; axi_ar_chl_bits_arprot = 0;
        axi_r_chl_ready = 0;
        axi_aw_chl_valid = 0; axi_aw_chl_bits_awid = 0; axi_aw_chl_bits_awaddr = 0;
        axi_aw_chl_bits_awsize = 0; axi_aw_chl_bits_awlen = 0; axi_aw_chl_bits_awbusrt = 0;
        axi_aw_chl_bits_awlock = 0; axi_aw_chl_bits_awcache = 0; axi_aw_chl_bits_awprot = 0;
        axi_w_chl_valid = 0; axi_w_chl_bits_wdata = 0; axi_w_chl_bits_wid = 0;
        axi_w_chl_bits_wstrb = 0; axi_w_chl_bits_wlast = 0;
        axi_b_chl_ready = 0;

`ifdef AXI_SRAM_ERR_RESP_EN
        e_err    = 2'b10;
        e_word0  = 32'h0123_4567;
        e_ovf_rd = 32'h0;
`else
        e_err    = 2'b00;
        e_word0  = 32'hCAFE_F00D;
        e_ovf_rd = 32'h0BAD_CAFE;
`endif

        //          wr  id     addr           len   burst  size  data           strb   tg  exp_first      resp
        tbl.push_back('{1, 4'h1, 32'h8000_0010, 4'd0, 2'b01, 3'd2, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         2'b00});
        tbl.push_back('{0, 4'h2, 32'h8000_0010, 4'd0, 2'b01, 3'd2, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 2'b00});
        tbl.push_back('{1, 4'h3, 32'h8000_0100, 4'd3, 2'b01, 3'd2, 32'h1,         4'hF, 0, 32'h0,         2'b00});
        tbl.push_back('{0, 4'h4, 32'h8000_0100, 4'd3, 2'b01, 3'd2, 32'h0,         4'h0, 1, 32'h1,         2'b00});
        tbl.push_back('{0, 4'h5, 32'h8000_0108, 4'd3, 2'b10, 3'd2, 32'h0,         4'h0, 0, 32'h3,         2'b00});
        tbl.push_back('{1, 4'h6, 32'h8000_0200, 4'd2, 2'b00, 3'd2, 32'h50,        4'hF, 0, 32'h0,         2'b00});
        tbl.push_back('{0, 4'h7, 32'h8000_0200, 4'd0, 2'b01, 3'd2, 32'h0,         4'h0, 0, 32'h52,        2'b00});
        tbl.push_back('{1, 4'h8, 32'h8000_0300, 4'd0, 2'b01, 3'd2, 32'h1122_3344, 4'hF, 0, 32'h0,         2'b00});
        tbl.push_back('{1, 4'h9, 32'h8000_0300, 4'd0, 2'b01, 3'd2, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         2'b00});
        tbl.push_back('{0, 4'hA, 32'h8000_0300, 4'd0, 2'b01, 3'd2, 32'h0,         4'h0, 0, 32'h11BB_33DD, 2'b00});
        tbl.push_back('{0, 4'hB, 32'h8000_0101, 4'd3, 2'b01, 3'd0, 32'h0,         4'h0, 1, 32'h1,         2'b00});
        tbl.push_back('{1, 4'hC, 32'h8000_0000, 4'd0, 2'b01, 3'd2, 32'h0123_4567, 4'hF, 0, 32'h0,         2'b00});
        tbl.push_back('{1, 4'hD, 32'h8000_0FFC, 4'd0, 2'b01, 3'd2, 32'h0BAD_CAFE, 4'hF, 0, 32'h0,         2'b00});
        tbl.push_back('{1, 4'hE, 32'h8000_1000, 4'd0, 2'b01, 3'd2, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         e_err});
        tbl.push_back('{0, 4'hF, 32'h8000_0000, 4'd0, 2'b01, 3'd2, 32'h0,         4'h0, 0, e_word0,       2'b00});
        tbl.push_back('{0, 4'h0, 32'h7FFF_FFFC, 4'd0, 2'b01, 3'd2, 32'h0,         4'h0, 0, e_ovf_rd,      e_err});

        // ---------------- reset values ----------------
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("rst_arready", 32'(axi_ar_chl_ready), 32'd0);
        check("rst_awready", 32'(axi_aw_chl_ready), 32'd0);
        check("rst_wready",  32'(axi_w_chl_ready),  32'd0);
        check("rst_rvalid",  32'(axi_r_chl_valid),  32'd0);
        check("rst_bvalid",  32'(axi_b_chl_valid),  32'd0);
        check("rst_rdata",   axi_r_chl_bits_rdata,  32'd0);
        check("rst_rid",     32'(axi_r_chl_bits_rid),   32'd0);
        check("rst_rresp",   32'(axi_r_chl_bits_rresp), 32'd0);
        check("rst_rlast",   32'(axi_r_chl_bits_rlast), 32'd0);
        check("rst_bid",     32'(axi_b_chl_bits_bid),   32'd0);
        check("rst_bresp",   32'(axi_b_chl_bits_bresp), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // ---------------- table-driven transactions ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size,
                         tbl[i].data, tbl[i].strb, fr);
                check($sformatf("vec%0d_bresp", i), 32'(fr), 32'(tbl[i].exp_resp));
            end else begin
                do_read(tbl[i].id, tbl[i].addr, tbl[i].len, tbl[i].burst, tbl[i].size,
                        tbl[i].toggle, fd, fr);
                check($sformatf("vec%0d_rdata", i), fd, tbl[i].exp_first);
                check($sformatf("vec%0d_rresp", i), 32'(fr), 32'(tbl[i].exp_resp));
            end
        end

        // ---------------- arbitration after reset ----------------
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        axi_ar_chl_valid = 1'b1; axi_ar_chl_bits_arid = 4'h1; axi_ar_chl_bits_araddr = 32'h8000_0010;
        axi_ar_chl_bits_arlen = 4'd0; axi_ar_chl_bits_arsize = 3'd2; axi_ar_chl_bits_arbusrt = 2'b01;
        axi_aw_chl_valid = 1'b1; axi_aw_chl_bits_awid = 4'h2; axi_aw_chl_bits_awaddr = 32'h8000_0400;
        axi_aw_chl_bits_awlen = 4'd0; axi_aw_chl_bits_awsize = 3'd2; axi_aw_chl_bits_awbusrt = 2'b01;
        #1;
        check("arb1_arready", 32'(axi_ar_chl_ready), 32'd1);
        check("arb1_awready", 32'(axi_aw_chl_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        axi_ar_chl_valid = 1'b0;
        #1;
        check("arb1_rvalid", 32'(axi_r_chl_valid), 32'd1);
        check("arb1_rdata", axi_r_chl_bits_rdata, 32'hDEAD_BEEF);
        check("arb1_aw_wait", 32'(axi_aw_chl_ready), 32'd0);
        axi_r_chl_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_r_chl_ready = 1'b0;
        // Second collision while the write is still pending: write must win.
        axi_ar_chl_valid = 1'b1; axi_ar_chl_bits_arid = 4'h3; axi_ar_chl_bits_araddr = 32'h8000_0400;
        #1;
        check("arb2_awready", 32'(axi_aw_chl_ready), 32'd1);
        check("arb2_arready", 32'(axi_ar_chl_ready), 32'd0);
        @(posedge clock);
        @(negedge clock);
        axi_aw_chl_valid = 1'b0;
        axi_w_chl_valid = 1'b1; axi_w_chl_bits_wdata = 32'h1357_9BDF; axi_w_chl_bits_wstrb = 4'hF;
        #1 check("arb2_wready", 32'(axi_w_chl_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        axi_w_chl_valid = 1'b0;
        #1;
        check("arb2_bvalid", 32'(axi_b_chl_valid), 32'd1);
        check("arb2_bid", 32'(axi_b_chl_bits_bid), 32'h2);
        check("arb2_bresp", 32'(axi_b_chl_bits_bresp), 32'd0);
        axi_b_chl_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_b_chl_ready = 1'b0;
        #1 check("arb3_arready", 32'(axi_ar_chl_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        axi_ar_chl_valid = 1'b0;
        #1;
        check("arb3_rvalid", 32'(axi_r_chl_valid), 32'd1);
        check("arb3_rdata", axi_r_chl_bits_rdata, 32'h1357_9BDF);
        check("arb3_rid", 32'(axi_r_chl_bits_rid), 32'h3);
        axi_r_chl_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        axi_r_chl_ready = 1'b0;
        #1 check("arb3_end", 32'(axi_r_chl_valid), 32'd0);

        // ---------------- reset in the middle of a read burst ----------------
        @(negedge clock);
        axi_ar_chl_valid = 1'b1; axi_ar_chl_bits_arid = 4'h4; axi_ar_chl_bits_araddr = 32'h8000_0100;
        axi_ar_chl_bits_arlen = 4'd7; axi_ar_chl_bits_arsize = 3'd2; axi_ar_chl_bits_arbusrt = 2'b01;
        wait_hi(0, "mid_ar_ready");
        @(posedge clock);
        @(negedge clock);
        axi_ar_chl_valid = 1'b0;
        axi_r_chl_ready = 1'b1;
        #1 check("mid_beat0", axi_r_chl_bits_rdata, 32'h1);
        @(posedge clock);
        @(negedge clock);
        #1 check("mid_beat1", axi_r_chl_bits_rdata, 32'h2);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        #1 check("mid_rst_rvalid", 32'(axi_r_chl_valid), 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            #1 if (axi_r_chl_valid) seen = 1;
        end
        check("mid_no_more_beats", 32'(seen), 32'd0);
        axi_r_chl_ready = 1'b0;

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
